// File: rtl/accel_sketch_nios2_gen2_0_cpu_mul_combine_if.sv
// Pipeline-side bundle between the CPU M stage and the multiply combine block.
// master = upstream pipeline, slave = combine block.
interface accel_sketch_nios2_gen2_0_cpu_mul_combine_if #(
    parameter int HALF_W = 16
);
    logic                  M_en;
    logic                  M_mul_start;
    logic                  M_mulx;
    logic [2*HALF_W-1:0]   M_mul_cell_p1;
    logic [2*HALF_W-1:0]   M_mul_cell_p2;
    logic [2*HALF_W-1:0]   M_mul_cell_p3;
    logic [HALF_W-1:0]     M_src1_hi;
    logic [HALF_W-1:0]     M_src2_hi;
    logic [2*HALF_W-1:0]   A_mul_result;
    logic                  A_mul_valid;
    logic                  M_mul_stall;

    modport master (
        output M_en, M_mul_start, M_mulx,
        output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        output M_src1_hi, M_src2_hi,
        input  A_mul_result, A_mul_valid, M_mul_stall
    );

    modport slave (
        input  M_en, M_mul_start, M_mulx,
        input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        input  M_src1_hi, M_src2_hi,
        output A_mul_result, A_mul_valid, M_mul_stall
    );
endinterface

// File: rtl/accel_sketch_nios2_gen2_0_cpu_mul_combine.sv
// Combines the mult cell partial products into the 32-bit MUL word; with macro
// MUL_COMBINE_MULX_EN an iterative shift-add engine also returns the MULXUU high word.
module accel_sketch_nios2_gen2_0_cpu_mul_combine #(
    parameter int HALF_W        = 16,
    parameter int BITS_PER_STEP = 1
) (
    input  logic clk,
    input  logic reset,
    accel_sketch_nios2_gen2_0_cpu_mul_combine_if.slave bus
);
    localparam int W = 2 * HALF_W;

    // Carry of p2+p3 out of bit HALF_W-1 falls off the top of the low word.
    logic [W-1:0] cross_sum;
    logic [W-1:0] lo_word;
    assign cross_sum = bus.M_mul_cell_p2 + bus.M_mul_cell_p3;
    assign lo_word   = bus.M_mul_cell_p1 + (cross_sum << HALF_W);

`ifdef MUL_COMBINE_MULX_EN
    localparam int ITER  = HALF_W / BITS_PER_STEP;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, ITER_S, DONE} state_t;

    state_t            state_reg, state_next;
    logic [W-1:0]      acc_reg, acc_next;
    logic [W-1:0]      p1_reg, p1_next, p2_reg, p2_next, p3_reg, p3_next;
    logic [W-1:0]      mcand_reg, mcand_next;
    logic [HALF_W-1:0] mplier_reg, mplier_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [W-1:0]      result_reg, result_next;
    logic              valid_reg, valid_next;

    logic [W-1:0]      step_term;
    logic [W:0]        cross_wide;
    logic [W-1:0]      hi_word;
    logic [W-1:0]      hi_unused_low;

    // a.hi is pre-shifted left each step so the retired multiplier chunk needs no shift.
    assign step_term  = mcand_reg * {{(W-BITS_PER_STEP){1'b0}}, mplier_reg[BITS_PER_STEP-1:0]};
    assign cross_wide = {1'b0, p2_reg} + {1'b0, p3_reg};
    assign {hi_word, hi_unused_low} = {acc_reg, {W{1'b0}}}
                                    + ({{(W-1){1'b0}}, cross_wide} << HALF_W)
                                    + {{W{1'b0}}, p1_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            p1_reg     <= '0;
            p2_reg     <= '0;
            p3_reg     <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            p1_reg     <= p1_next;
            p2_reg     <= p2_next;
            p3_reg     <= p3_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            count_reg  <= count_next;
            result_reg <= result_next;
            valid_reg  <= valid_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        p1_next     = p1_reg;
        p2_next     = p2_reg;
        p3_next     = p3_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        count_next  = count_reg;
        result_next = result_reg;
        valid_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.M_en && bus.M_mul_start) begin
                    if (bus.M_mulx) begin
                        p1_next     = bus.M_mul_cell_p1;
                        p2_next     = bus.M_mul_cell_p2;
                        p3_next     = bus.M_mul_cell_p3;
                        mcand_next  = {{HALF_W{1'b0}}, bus.M_src1_hi};
                        mplier_next = bus.M_src2_hi;
                        acc_next    = '0;
                        count_next  = CNT_W'(ITER);
                        state_next  = ITER_S;
                    end else begin
                        result_next = lo_word;
                        valid_next  = 1'b1;
                    end
                end
            end
            ITER_S: begin
                acc_next    = acc_reg + step_term;
                mcand_next  = mcand_reg << BITS_PER_STEP;
                mplier_next = mplier_reg >> BITS_PER_STEP;
                count_next  = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Retiring edge never looks at M_mul_start; a coincident start is dropped.
                if (bus.M_en) begin
                    result_next = hi_word;
                    valid_next  = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.A_mul_result = result_reg;
    assign bus.A_mul_valid  = valid_reg;
    assign bus.M_mul_stall  = (state_reg != IDLE);
`else
    logic [W-1:0] result_reg;
    logic         valid_reg;
    logic         unused_mulx_inputs;

    assign unused_mulx_inputs = ^{bus.M_mulx, bus.M_src1_hi, bus.M_src2_hi, BITS_PER_STEP[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= bus.M_en && bus.M_mul_start;
            if (bus.M_en && bus.M_mul_start) begin
                result_reg <= lo_word;
            end
        end
    end

    assign bus.A_mul_result = result_reg;
    assign bus.A_mul_valid  = valid_reg;
    assign bus.M_mul_stall  = 1'b0;
`endif
endmodule
